// File: rtl/multicycle_alu.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Non-shift operations and zero-amount shifts finish in one cycle; shifts with a
// non-zero amount step one bit position per cycle. The result and flags are registered
// and held until the next result is loaded.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   in_valid   - request valid;     in_ready  - block is idle and can accept
//   ALUControl - operation code;    SrcA/SrcB - operands (SrcB[4:0] = shift amount)
//   out_valid  - result valid;      out_ready - consumer takes the result
//   ALUResult  - registered result; Zero/Illegal - registered flags
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Illegal
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSrl = 4'b0111;
  localparam logic [3:0] OpSra = 4'b1000;

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sh_step;
  logic [4:0]       shamt;
  logic             is_shift;
  logic             is_illegal;

  assign shamt      = SrcB[4:0];
  assign is_shift   = (ALUControl == OpSll) || (ALUControl == OpSrl) || (ALUControl == OpSra);
  assign is_illegal = (ALUControl > 4'd9);

  // Single-cycle results; shift codes only reach this path with a zero amount.
  always_comb begin
    alu_res = '0;
    case (ALUControl)
      4'b0000: alu_res = SrcA + SrcB;
      4'b0001: alu_res = SrcA - SrcB;
      4'b0010: alu_res = SrcA & SrcB;
      4'b0011: alu_res = SrcA | SrcB;
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'b0110: alu_res = SrcA ^ SrcB;
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OpSll, OpSrl, OpSra: alu_res = SrcA;
      default: alu_res = '0;
    endcase
  end

  // One-bit step; sra re-inserts the top bit, which is still the captured SrcA MSB.
  always_comb begin
    sh_step = sh_q;
    case (op_q)
      OpSll:   sh_step = {sh_q[WIDTH-2:0], 1'b0};
      OpSrl:   sh_step = {1'b0, sh_q[WIDTH-1:1]};
      default: sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = ALUControl;
          if (is_illegal) begin
            res_d   = '0;
            zero_d  = 1'b1;
            ill_d   = 1'b1;
            state_d = DONE;
          end else if (is_shift && (shamt != 5'd0)) begin
            sh_d    = SrcA;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            ill_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_q - 5'd1;
        // Last step: publish the shifted value; outputs stay untouched until then.
        if (cnt_q == 5'd1) begin
          res_d   = sh_step;
          zero_d  = (sh_step == '0);
          ill_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign Illegal   = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Illegal;

  int checks = 0;
  int errors = 0;

  // Model state: expectation for the request in flight.
  logic [31:0] exp_res;
  logic        exp_zero;
  logic        exp_ill;
  int          exp_lat;
  bit          model_pending = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole operation in one step, plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
    case (code)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << b[4:0];
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return a ^ b;
      4'd7:    return a >> b[4:0];
      4'd8:    return $unsigned($signed(a) >>> b[4:0]);
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Compare process: whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      chk("valid_expected", {31'd0, model_pending}, 32'd1);
      chk("result", ALUResult, exp_res);
      chk("zero", {31'd0, Zero}, {31'd0, exp_zero});
      chk("illegal", {31'd0, Illegal}, {31'd0, exp_ill});
    end
  end

  task automatic scramble();
    in_valid   = 1'($urandom);
    ALUControl = 4'($urandom);
    SrcA       = $urandom;
    SrcB       = $urandom;
  endtask

  task automatic do_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit use_lit, input logic [31:0] lit);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    exp_res  = ref_alu(code, a, b);
    exp_ill  = (code > 4'd9);
    exp_zero = (exp_res == 32'd0);
    exp_lat  = ((code == 4'd4 || code == 4'd7 || code == 4'd8) && b[4:0] != 5'd0)
               ? 1 + int'(b[4:0]) : 1;
    in_valid   = 1'b1;
    ALUControl = code;
    SrcA       = a;
    SrcB       = b;
    out_ready  = 1'b0;
    @(posedge clk);
    model_pending = 1;
    @(negedge clk);
    lat = 1;
    scramble();
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      scramble();
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (use_lit) chk("literal_result", ALUResult, lit);
    for (int i = 0; i < hold; i++) begin
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      chk("valid_held", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      scramble();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    model_pending = 0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("result_kept", ALUResult, exp_res);
    chk("zero_kept", {31'd0, Zero}, {31'd0, exp_zero});
    chk("illegal_kept", {31'd0, Illegal}, {31'd0, exp_ill});
  endtask

  // Start an 8-step shift, then pulse reset in the middle of it.
  task automatic reset_mid_shift();
    @(negedge clk);
    in_valid   = 1'b1;
    ALUControl = 4'd4;
    SrcA       = 32'h0000_00F1;
    SrcB       = 32'd8;
    out_ready  = 1'b0;
    @(posedge clk);
    model_pending = 1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", {31'd0, in_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    model_pending = 0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd0);
    chk("rst_illegal", {31'd0, Illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    // Aborted shift must never complete.
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    reset      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 4'd0;
    SrcA       = 32'd0;
    SrcB       = 32'd0;
    #2;
    chk("init_in_ready", {31'd0, in_ready}, 32'd1);
    chk("init_out_valid", {31'd0, out_valid}, 32'd0);
    chk("init_result", ALUResult, 32'd0);
    chk("init_zero", {31'd0, Zero}, 32'd0);
    chk("init_illegal", {31'd0, Illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op(4'd0, 32'hFFFF_FFFF, 32'd1,          0, 1, 32'h0000_0000);
    do_op(4'd1, 32'd5,         32'd7,          0, 1, 32'hFFFF_FFFE);
    do_op(4'd5, 32'hFFFF_FFFF, 32'd1,          0, 1, 32'h0000_0001);
    do_op(4'd9, 32'hFFFF_FFFF, 32'd1,          0, 1, 32'h0000_0000);
    do_op(4'd8, 32'h8000_0000, 32'd31,         0, 1, 32'hFFFF_FFFF);
    do_op(4'd7, 32'h8000_0000, 32'd31,         0, 1, 32'h0000_0001);
    do_op(4'd4, 32'h0000_1234, 32'h0000_0020,  0, 1, 32'h0000_1234);
    do_op(4'd4, 32'h0000_0003, 32'd4,          0, 1, 32'h0000_0030);
    do_op(4'd6, 32'hA5A5_0F0F, 32'h0F0F_A5A5,  5, 1, 32'hAAAA_AAAA);
    do_op(4'd10, 32'h1234_5678, 32'h1,         5, 1, 32'h0000_0000);
    reset_mid_shift();
    do_op(4'd15, 32'hDEAD_BEEF, 32'h3,         0, 1, 32'h0000_0000);
    do_op(4'd3, 32'h00F0_0000, 32'h0000_000F,  0, 1, 32'h00F0_000F);
    reset_mid_shift();
    do_op(4'd8, 32'h7000_0000, 32'd4,          1, 1, 32'h0700_0000);

    for (int n = 0; n < 200; n++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) a = b;
      do_op(c, a, b, $urandom_range(0, 3), 0, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
